aes_round_downcounter: RTL and testbench

- Loadable round down-counter with start/done handshake that sequences AES rounds.
- On start it loads the round count NR and decrements it once per advance strobe.
- It flags the first and final rounds and pulses done when the count is exhausted.
- Sits between the top-level controller and the round datapath; it complements the existing free-running 4-bit up-counter.

---
 rtl/aes_round_downcounter.sv | 111 +++++++++++
 tb/tb_aes_round_downcounter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_downcounter.sv
// rtl/aes_round_downcounter.sv - AES round down-counter with start/done handshake
// Optional round-constant output enabled by macro AES_ROUND_RCON_EN.
module aes_round_downcounter #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       adv,
    output logic [3:0] rnd,
    output logic       busy,
    output logic       first_round,
    output logic       final_round,
`ifdef AES_ROUND_RCON_EN
    output logic       done,
    output logic [7:0] rcon
`else
    output logic       done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] NR_L = 4'(NR);

    state_e     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                rnd_d = 4'd0;
                // start wins over adv here: the count loads NR, never NR-1
                if (start) begin
                    rnd_d   = NR_L;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (adv) begin
                    if (rnd_q > 4'd1) begin
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        rnd_d   = 4'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rnd_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                rnd_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign rnd         = rnd_q;
    assign busy        = (state_q == S_RUN);
    assign first_round = (state_q == S_RUN) && (rnd_q == NR_L);
    assign final_round = (state_q == S_RUN) && (rnd_q == 4'd1);
    assign done        = (state_q == S_DONE);

`ifdef AES_ROUND_RCON_EN
    logic [7:0] rcon_q, rcon_d;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    // DONE keeps the last xtime result; the value clears on the way into IDLE
    always_comb begin
        rcon_d = rcon_q;
        case (state_q)
            S_IDLE:  rcon_d = start ? 8'h01 : 8'h00;
            S_RUN:   rcon_d = adv ? xtime(rcon_q) : rcon_q;
            S_DONE:  rcon_d = 8'h00;
            default: rcon_d = 8'h00;
        endcase
    end

    assign rcon = rcon_q;
`endif

endmodule

// File: tb/tb_aes_round_downcounter.sv
// tb/tb_aes_round_downcounter.sv - self-checking bench for aes_round_downcounter
module tb_aes_round_downcounter;
    localparam int NR     = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       adv   = 1'b0;
    logic [3:0] rnd;
    logic       busy, first_round, final_round, done;
`ifdef AES_ROUND_RCON_EN
    logic [7:0] rcon;
`endif

    int errors = 0;
    int checks = 0;
    int m_mode = M_IDLE;
    int m_advs = 0;

    always #5 clk = ~clk;

    aes_round_downcounter #(.NR(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .adv         (adv),
        .rnd         (rnd),
        .busy        (busy),
        .first_round (first_round),
        .final_round (final_round),
`ifdef AES_ROUND_RCON_EN
        .done        (done),
        .rcon        (rcon)
`else
        .done        (done)
`endif
    );

    function automatic logic [7:0] obs_vec();
        return {rnd, busy, first_round, final_round, done};
    endfunction

    // rounds remaining = NR minus rounds already completed
    function automatic logic [7:0] exp_vec();
        int r;
        r = (m_mode == M_RUN) ? NR - m_advs : 0;
        return {4'(r), m_mode == M_RUN, (m_mode == M_RUN) && (r == NR),
                (m_mode == M_RUN) && (r == 1), m_mode == M_DONE};
    endfunction

    function automatic logic [7:0] exp_rcon();
        logic [7:0] tab [0:9];
        tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        if (m_mode == M_RUN) return tab[m_advs];
        if (m_mode == M_DONE) return 8'h6C;
        return 8'h00;
    endfunction

    task automatic model_edge(input logic s, input logic a);
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_RUN; m_advs = 0; end
            M_RUN: if (a) begin
                m_advs++;
                if (m_advs == NR) m_mode = M_DONE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_advs = 0;
    endtask

    task automatic step(input logic s, input logic a);
        start = s;
        adv   = a;
        @(posedge clk);
        model_edge(s, a);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom);
            adv   = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_vec() !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 00", obs_vec());
            end
`ifdef AES_ROUND_RCON_EN
            checks++;
            if (rcon !== 8'h00) begin
                errors++;
                $display("FAIL reset_rcon: got %h expected 00", rcon);
            end
`endif
        end
        start = 1'b0;
        adv   = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        step(1'b1, 1'b1);
        checks++;
        if (rnd !== 4'd10 || first_round !== 1'b1 || busy !== 1'b1 || final_round !== 1'b0) begin
            errors++;
            $display("FAIL nominal_load: rnd=%0d first=%b busy=%b final=%b expected 10 1 1 0",
                     rnd, first_round, busy, final_round);
        end
        for (int k = 2; k <= 10; k++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL nominal_cycle%0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
`ifdef AES_ROUND_RCON_EN
            checks++;
            if (rcon !== exp_rcon()) begin
                errors++;
                $display("FAIL nominal_rcon%0d: got %h expected %h", k, rcon, exp_rcon());
            end
`endif
        end
        checks++;
        if (rnd !== 4'd1 || final_round !== 1'b1 || first_round !== 1'b0) begin
            errors++;
            $display("FAIL nominal_final: rnd=%0d final=%b first=%b expected 1 1 0",
                     rnd, final_round, first_round);
        end
        step(1'b0, 1'b1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rnd !== 4'd0) begin
            errors++;
            $display("FAIL nominal_done: done=%b busy=%b rnd=%0d expected 1 0 0", done, busy, rnd);
        end
        step(1'b0, 1'b1);
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL nominal_idle: got %h expected 00", obs_vec());
        end
`ifdef AES_ROUND_RCON_EN
        checks++;
        if (rcon !== 8'h00) begin
            errors++;
            $display("FAIL nominal_rcon_idle: got %h expected 00", rcon);
        end
`endif
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (rnd !== 4'd7 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: rnd=%0d busy=%b expected 7 1", i, rnd, busy);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (rnd !== 4'd6) begin
            errors++;
            $display("FAIL stall_resume: rnd=%0d expected 6", rnd);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || m_mode != M_IDLE) begin
            errors++;
            $display("FAIL stall_end: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_start_while_busy();
        step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (rnd !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: rnd=%0d busy=%b expected 3 1", rnd, busy);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_reach_done: done=%b expected 1", done);
        end
        step(1'b1, 1'b1);
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL done_start_ignored: got %h expected 00", obs_vec());
        end
        step(1'b1, 1'b1);
        checks++;
        if (rnd !== 4'd10 || first_round !== 1'b1) begin
            errors++;
            $display("FAIL idle_restart: rnd=%0d first=%b expected 10 1", rnd, first_round);
        end
    endtask

    task automatic test_async_reset();
        while (m_mode != M_IDLE) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        checks++;
        if (rnd !== 4'd3) begin
            errors++;
            $display("FAIL async_setup: rnd=%0d expected 3", rnd);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL async_drop: got %h expected 00", obs_vec());
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_vec() !== 8'h00) begin
                errors++;
                $display("FAIL async_no_done%0d: got %h expected 00", i, obs_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        gap = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && gap == 0; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (first_round === 1'b1) gap = i + 1;
        end
        checks++;
        if (gap != NR + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected %0d", gap, NR + 2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
`ifdef AES_ROUND_RCON_EN
            checks++;
            if (rcon !== exp_rcon()) begin
                errors++;
                $display("FAIL random_rcon%0d: got %h expected %h", i, rcon, exp_rcon());
            end
`endif
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_nominal();
        test_stall();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
